adpcm: RTL and testbench

ADPCM -- requirements
Module: adpcm

---
 rtl/adpcm.sv | 233 +++++++++++++++++++++++
 tb/tb_adpcm.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm.sv
// ---------------------------------------------------------------------------
// adpcm -- IMA ADPCM encoder/decoder sharing one predictor and step index.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rstn      in   1   asynchronous active-low reset
//   enable    in   1   codec enable; low clears predictor/index, ignores req
//   sel_rx    in   1   0 = encode (rx_pcm -> tx_adpcm), 1 = decode (rx_adpcm)
//   req       in   1   toggle request; each level change is one conversion
//   ack       out  1   one-cycle completion pulse, outputs valid while high
//   rx_pcm    in  16   signed PCM sample to encode
//   tx_adpcm  out  4   IMA code {sign, magnitude[2:0]}
//   rx_adpcm  in   4   IMA code to decode
//   tx_pcm    out 16   signed reconstructed sample (the new predictor)
//
// Handshake: a request is any level change of req seen while enable is high.
// The conversion is committed on the edge that detects it and ack is high for
// exactly the next cycle with tx_adpcm/tx_pcm already updated. Toggles on
// consecutive cycles each produce their own conversion and ack pulse.
//
// Build option: define ADPCM_REQ_SYNC_EN to pass req through a two-flop
// synchronizer ahead of the edge detector (req toggle to ack becomes 3 clocks).
// ---------------------------------------------------------------------------
module adpcm (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               sel_rx,
    input  logic               req,
    output logic               ack,
    input  logic signed [15:0] rx_pcm,
    output logic        [3:0]  tx_adpcm,
    input  logic        [3:0]  rx_adpcm,
    output logic        [15:0] tx_pcm
);

    localparam logic [14:0] STEP_INIT = 15'd7;

    // Standard 89-entry IMA step table.
    function automatic logic [14:0] step_lut(input logic [6:0] i);
        case (i)
            7'd0:  step_lut = 15'd7;     7'd1:  step_lut = 15'd8;
            7'd2:  step_lut = 15'd9;     7'd3:  step_lut = 15'd10;
            7'd4:  step_lut = 15'd11;    7'd5:  step_lut = 15'd12;
            7'd6:  step_lut = 15'd13;    7'd7:  step_lut = 15'd14;
            7'd8:  step_lut = 15'd16;    7'd9:  step_lut = 15'd17;
            7'd10: step_lut = 15'd19;    7'd11: step_lut = 15'd21;
            7'd12: step_lut = 15'd23;    7'd13: step_lut = 15'd25;
            7'd14: step_lut = 15'd28;    7'd15: step_lut = 15'd31;
            7'd16: step_lut = 15'd34;    7'd17: step_lut = 15'd37;
            7'd18: step_lut = 15'd41;    7'd19: step_lut = 15'd45;
            7'd20: step_lut = 15'd50;    7'd21: step_lut = 15'd55;
            7'd22: step_lut = 15'd60;    7'd23: step_lut = 15'd66;
            7'd24: step_lut = 15'd73;    7'd25: step_lut = 15'd80;
            7'd26: step_lut = 15'd88;    7'd27: step_lut = 15'd97;
            7'd28: step_lut = 15'd107;   7'd29: step_lut = 15'd118;
            7'd30: step_lut = 15'd130;   7'd31: step_lut = 15'd143;
            7'd32: step_lut = 15'd157;   7'd33: step_lut = 15'd173;
            7'd34: step_lut = 15'd190;   7'd35: step_lut = 15'd209;
            7'd36: step_lut = 15'd230;   7'd37: step_lut = 15'd253;
            7'd38: step_lut = 15'd279;   7'd39: step_lut = 15'd307;
            7'd40: step_lut = 15'd337;   7'd41: step_lut = 15'd371;
            7'd42: step_lut = 15'd408;   7'd43: step_lut = 15'd449;
            7'd44: step_lut = 15'd494;   7'd45: step_lut = 15'd544;
            7'd46: step_lut = 15'd598;   7'd47: step_lut = 15'd658;
            7'd48: step_lut = 15'd724;   7'd49: step_lut = 15'd796;
            7'd50: step_lut = 15'd876;   7'd51: step_lut = 15'd963;
            7'd52: step_lut = 15'd1060;  7'd53: step_lut = 15'd1166;
            7'd54: step_lut = 15'd1282;  7'd55: step_lut = 15'd1411;
            7'd56: step_lut = 15'd1552;  7'd57: step_lut = 15'd1707;
            7'd58: step_lut = 15'd1878;  7'd59: step_lut = 15'd2066;
            7'd60: step_lut = 15'd2272;  7'd61: step_lut = 15'd2499;
            7'd62: step_lut = 15'd2749;  7'd63: step_lut = 15'd3024;
            7'd64: step_lut = 15'd3327;  7'd65: step_lut = 15'd3660;
            7'd66: step_lut = 15'd4026;  7'd67: step_lut = 15'd4428;
            7'd68: step_lut = 15'd4871;  7'd69: step_lut = 15'd5358;
            7'd70: step_lut = 15'd5894;  7'd71: step_lut = 15'd6484;
            7'd72: step_lut = 15'd7132;  7'd73: step_lut = 15'd7845;
            7'd74: step_lut = 15'd8630;  7'd75: step_lut = 15'd9493;
            7'd76: step_lut = 15'd10442; 7'd77: step_lut = 15'd11487;
            7'd78: step_lut = 15'd12635; 7'd79: step_lut = 15'd13899;
            7'd80: step_lut = 15'd15289; 7'd81: step_lut = 15'd16818;
            7'd82: step_lut = 15'd18500; 7'd83: step_lut = 15'd20350;
            7'd84: step_lut = 15'd22385; 7'd85: step_lut = 15'd24623;
            7'd86: step_lut = 15'd27086; 7'd87: step_lut = 15'd29794;
            default: step_lut = 15'd32767;
        endcase
    endfunction

    // Index adjustment keyed by the 3-bit magnitude of the code.
    function automatic logic signed [7:0] idx_adj(input logic [2:0] d);
        case (d)
            3'd4:    idx_adj = 8'sd2;
            3'd5:    idx_adj = 8'sd4;
            3'd6:    idx_adj = 8'sd6;
            3'd7:    idx_adj = 8'sd8;
            default: idx_adj = -8'sd1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Request detection
    // ------------------------------------------------------------------
    logic req_q;
    logic req_src;
    logic req_hit;

`ifdef ADPCM_REQ_SYNC_EN
    logic req_s1;
    logic req_s2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
        end else begin
            req_s1 <= req;
            req_s2 <= req_s1;
        end
    end

    assign req_src = req_s2;
`else
    assign req_src = req;
`endif

    assign req_hit = enable && (req_src != req_q);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [15:0] predict;
    logic        [6:0]  idx;
    // Registered alongside idx so it always equals step_lut(idx) without a
    // second table lookup in the datapath.
    logic        [14:0] step;

    logic        [16:0] step_w;
    logic signed [16:0] diff;
    logic        [16:0] mag;
    logic        [16:0] rem1;
    logic        [16:0] rem2;
    logic               b2;
    logic               b1;
    logic               b0;
    logic        [3:0]  code;
    logic        [2:0]  delta;
    logic        [16:0] sigma;
    logic signed [18:0] pred_sum;
    logic signed [15:0] predict_nxt;
    logic signed [7:0]  idx_sum;
    logic        [6:0]  clamp_idx;
    logic        [14:0] nst_step;

    assign step_w = {2'b00, step};
    assign diff   = $signed({rx_pcm[15], rx_pcm}) - $signed({predict[15], predict});
    assign mag    = diff[16] ? -diff : diff;

    // Successive approximation of |diff| against step, step/2, step/4.
    assign b2   = (mag >= step_w);
    assign rem1 = b2 ? (mag - step_w) : mag;
    assign b1   = (rem1 >= (step_w >> 1));
    assign rem2 = b1 ? (rem1 - (step_w >> 1)) : rem1;
    assign b0   = (rem2 >= (step_w >> 2));

    // Both modes reconstruct through the same path; only the code source differs.
    assign code  = sel_rx ? rx_adpcm : {diff[16], b2, b1, b0};
    assign delta = code[2:0];

    assign sigma = (step_w >> 3)
                 + (delta[2] ? step_w        : 17'd0)
                 + (delta[1] ? (step_w >> 1) : 17'd0)
                 + (delta[0] ? (step_w >> 2) : 17'd0);

    assign pred_sum = code[3]
                    ? ($signed({{3{predict[15]}}, predict}) - $signed({2'b00, sigma}))
                    : ($signed({{3{predict[15]}}, predict}) + $signed({2'b00, sigma}));

    always_comb begin
        predict_nxt = pred_sum[15:0];
        if (pred_sum > 19'sd32767) begin
            predict_nxt = 16'sh7fff;
        end else if (pred_sum < -19'sd32768) begin
            predict_nxt = 16'sh8000;
        end
    end

    assign idx_sum = $signed({1'b0, idx}) + idx_adj(delta);

    always_comb begin
        clamp_idx = idx_sum[6:0];
        if (idx_sum < 8'sd0) begin
            clamp_idx = 7'd0;
        end else if (idx_sum > 8'sd88) begin
            clamp_idx = 7'd88;
        end
    end

    assign nst_step = step_lut(clamp_idx);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q    <= 1'b0;
            predict  <= '0;
            idx      <= '0;
            step     <= STEP_INIT;
            tx_adpcm <= '0;
            tx_pcm   <= '0;
            ack      <= 1'b0;
        end else begin
            // req_q tracks req even while disabled, so re-enabling never
            // turns a stale level difference into a request.
            req_q <= req_src;
            ack   <= 1'b0;
            if (!enable) begin
                predict <= '0;
                idx     <= '0;
                step    <= STEP_INIT;
            end else if (req_hit) begin
                predict  <= predict_nxt;
                idx      <= clamp_idx;
                step     <= nst_step;
                tx_adpcm <= code;
                tx_pcm   <= predict_nxt;
                ack      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adpcm.sv
// ---------------------------------------------------------------------------
// tb_adpcm -- self-checking bench for adpcm.
// A C-style IMA reference model (integer arithmetic) predicts every
// conversion; expectations are queued and checked against tx_pcm/tx_adpcm
// on each ack pulse. Literal checks pin the model on hand-computed cases.
// ---------------------------------------------------------------------------
module tb_adpcm;

    localparam int W  = 21;   // {check_code, code[3:0], pcm[15:0]}
    localparam int NS = 3000; // round-trip sample count

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        enable   = 1'b0;
    logic        sel_rx   = 1'b0;
    logic        req      = 1'b0;
    logic        ack;
    logic [15:0] rx_pcm   = '0;
    logic [3:0]  tx_adpcm;
    logic [3:0]  rx_adpcm = '0;
    logic [15:0] tx_pcm;

    adpcm dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .sel_rx   (sel_rx),
        .req      (req),
        .ack      (ack),
        .rx_pcm   (rx_pcm),
        .tx_adpcm (tx_adpcm),
        .rx_adpcm (rx_adpcm),
        .tx_pcm   (tx_pcm)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    int issued  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int step_tab[89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
    int adj_tab[8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
    int m_pred = 0;
    int m_idx  = 0;

    function automatic void m_decode(input int code);
        int st;
        int vp;
        st = step_tab[m_idx];
        vp = st >> 3;
        if ((code & 4) != 0) vp += st;
        if ((code & 2) != 0) vp += st >> 1;
        if ((code & 1) != 0) vp += st >> 2;
        if ((code & 8) != 0) m_pred -= vp;
        else                 m_pred += vp;
        if (m_pred > 32767)       m_pred = 32767;
        else if (m_pred < -32768) m_pred = -32768;
        m_idx += adj_tab[code & 7];
        if (m_idx < 0)       m_idx = 0;
        else if (m_idx > 88) m_idx = 88;
    endfunction

    function automatic int m_encode(input int sample);
        int d;
        int st;
        int code;
        st   = step_tab[m_idx];
        d    = sample - m_pred;
        code = 0;
        if (d < 0) begin
            code = 8;
            d    = -d;
        end
        if (d >= st) begin
            code |= 4;
            d    -= st;
        end
        if (d >= (st >> 1)) begin
            code |= 2;
            d    -= st >> 1;
        end
        if (d >= (st >> 2)) code |= 1;
        m_decode(code);
        return code;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rstn && ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=1 expected no pending request");
            end else begin
                e = exp_q.pop_front();
                check("tx_pcm", 32'(tx_pcm), 32'(e[15:0]));
                if (e[20]) check("tx_adpcm", 32'(tx_adpcm), 32'(e[19:16]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input bit chk_code, input int code);
        logic [31:0] p;
        p = m_pred;
        exp_q.push_back({chk_code, 4'(code), p[15:0]});
    endtask

    task automatic send_enc(input int sample, output int code);
        logic [31:0] s;
        code = m_encode(sample);
        push_exp(1'b1, code);
        s = sample;
        @(negedge clk);
        #1;
        sel_rx = 1'b0;
        rx_pcm = s[15:0];
        req    = ~req;
        issued++;
    endtask

    task automatic send_dec(input int code);
        logic [31:0] c;
        m_decode(code);
        push_exp(1'b0, code);
        c = code;
        @(negedge clk);
        #1;
        sel_rx   = 1'b1;
        rx_adpcm = c[3:0];
        req      = ~req;
        issued++;
    endtask

    task automatic wait_acks();
        int n;
        n = 0;
        while (ack_cnt != issued && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (ack_cnt != issued) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", ack_cnt, issued);
            exp_q.delete();
            issued = ack_cnt;
        end else begin
            @(negedge clk);
            #1;
            check("ack_single_cycle", 32'(ack), 32'd0);
        end
    endtask

    task automatic enable_cycle();
        enable = 1'b0;
        cycles(3);
        check("en_low_predict", 32'(dut.predict), 32'd0);
        check("en_low_idx", 32'(dut.idx), 32'd0);
        enable = 1'b1;
        m_pred = 0;
        m_idx  = 0;
        cycles(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int s;
        int tri_v;
        int codes[NS];
        int enc_pcm[NS];
        int rt_bad;

        // Reset, with a req toggle that must be ignored.
        rstn = 1'b0;
        cycles(2);
        req = 1'b1;
        cycles(2);
        check("rst_tx_adpcm", 32'(tx_adpcm), 32'd0);
        check("rst_tx_pcm", 32'(tx_pcm), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        rstn = 1'b1;
        cycles(2);
        enable = 1'b1;
        cycles(3);
        check("idle_no_ack", 32'(ack_cnt), 32'd0);

        // Encode 1000 from cleared state: code 7, pcm 11, idx 8.
        send_enc(1000, c);
        wait_acks();
        check("enc1_model_code", 32'(c), 32'd7);
        check("enc1_model_pcm", 32'(m_pred), 32'd11);
        check("enc1_model_idx", 32'(m_idx), 32'd8);
        check("enc1_tx_adpcm", 32'(tx_adpcm), 32'd7);
        check("enc1_tx_pcm", 32'(tx_pcm), 32'd11);
        check("enc1_idx", 32'(dut.idx), 32'd8);

        // Mode change without a request does nothing.
        sel_rx   = 1'b1;
        rx_adpcm = 4'hf;
        cycles(4);
        check("sel_idle_acks", 32'(ack_cnt), 32'(issued));
        check("sel_idle_tx_pcm", 32'(tx_pcm), 32'd11);
        sel_rx = 1'b0;

        // Requests ignored while disabled; outputs hold.
        enable = 1'b0;
        cycles(2);
        req = ~req;
        cycles(3);
        check("dis_acks", 32'(ack_cnt), 32'(issued));
        check("dis_hold_tx_pcm", 32'(tx_pcm), 32'd11);
        check("dis_hold_tx_adpcm", 32'(tx_adpcm), 32'd7);
        enable_cycle();
        cycles(3);
        check("reen_no_ack", 32'(ack_cnt), 32'(issued));

        // Negative encode from cleared state: code 15, pcm -11, idx 8.
        send_enc(-1000, c);
        wait_acks();
        check("enc2_model_code", 32'(c), 32'd15);
        check("enc2_model_pcm", 32'(m_pred), 32'hffff_fff5);
        check("enc2_tx_adpcm", 32'(tx_adpcm), 32'd15);
        check("enc2_tx_pcm", 32'(tx_pcm), 32'h0000_fff5);
        check("enc2_idx", 32'(dut.idx), 32'd8);

        // Back-to-back toggles on consecutive cycles.
        send_enc(500, c);
        send_enc(-200, c);
        send_enc(3000, c);
        send_enc(3000, c);
        wait_acks();

        // Decode floor: code 0 ten times from cleared state.
        enable_cycle();
        for (int i = 0; i < 10; i++) send_dec(0);
        wait_acks();
        check("floor_tx_pcm", 32'(tx_pcm), 32'd0);
        check("floor_idx", 32'(dut.idx), 32'd0);

        // Positive saturation: code 7 a hundred times.
        for (int i = 0; i < 100; i++) send_dec(7);
        wait_acks();
        check("sat_model_idx", 32'(m_idx), 32'd88);
        check("sat_model_pcm", 32'(m_pred), 32'd32767);
        check("sat_idx", 32'(dut.idx), 32'd88);
        check("sat_tx_pcm", 32'(tx_pcm), 32'h0000_7fff);

        // Negative saturation: code 15 repeatedly.
        for (int i = 0; i < 20; i++) send_dec(15);
        wait_acks();
        check("nsat_tx_pcm", 32'(tx_pcm), 32'h0000_8000);

        // Round trip: encode a stream, then decode the captured codes.
        enable_cycle();
        for (int i = 0; i < NS; i++) begin
            tri_v = ((i % 400) < 200) ? (-30000 + (i % 200) * 300)
                                      : (30000 - (i % 200) * 300);
            s = tri_v + int'($urandom_range(0, 200)) - 100;
            if ((i % 97) == 0) s = ((i & 1) != 0) ? 32767 : -32768;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            send_enc(s, c);
            codes[i]   = c;
            enc_pcm[i] = m_pred;
        end
        wait_acks();
        enable_cycle();
        rt_bad = 0;
        for (int i = 0; i < NS; i++) begin
            send_dec(codes[i]);
            if (m_pred != enc_pcm[i]) rt_bad++;
        end
        wait_acks();
        check("rt_model_consistency", 32'(rt_bad), 32'd0);
        check("rt_final_tx_pcm", 32'(tx_pcm), 32'(enc_pcm[NS-1] & 32'h0000_ffff));
        check("rt_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
